// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and the multiply opcode shared by the accumulator ALU.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_MOV = 4'd6, OP_ADC = 4'd7,
    OP_SBB = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10, OP_MUL = 4'd11,
    OP_NOP = 4'd12
  } op_t;
  typedef enum logic {IDLE, MUL} state_t;
  localparam logic [3:0] MUL_OP = 4'd11;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-cycle shift-add multiplier; prod is valid combinationally while done is high.
module alu_mul_seq #(parameter int WIDTH = 8) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] mc, p;
  logic [WIDTH-1:0]   mp;
  logic [CW-1:0]      cnt;
  assign prod = p + (mp[0] ? mc : '0);
  assign done = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p   <= '0;
      mc  <= '0;
      mp  <= '0;
      cnt <= '0;
    end else if (start) begin
      p   <= '0;
      mc  <= {{WIDTH{1'b0}}, a};
      mp  <= b;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      p   <= prod;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: registered accumulator ALU with carry/zero flags and valid/ready command input.
// Define ALU_MUL_EN to add the multi-cycle shift-add MUL; otherwise opcode 11 is a NOP.
module alu_acc_seq
  import alu_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] acc,
  output logic             cy,
  output logic             z,
  output logic             done,
  output logic             busy
);
  state_t state;
  logic accept, wr, we, mul_start, mul_fin;
  logic [WIDTH:0] ext, res;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  // ext is {carry, result}; bit WIDTH doubles as borrow for the subtracting ops
  always_comb begin
    ext = {cy, acc};
    wr  = 1'b1;
    case (op_t'(op))
      OP_ADD:  ext = {1'b0, acc} + {1'b0, r};
      OP_SUB:  ext = {1'b0, acc} - {1'b0, r};
      OP_AND:  ext = {1'b0, acc & r};
      OP_OR:   ext = {1'b0, acc | r};
      OP_XOR:  ext = {1'b0, acc ^ r};
      OP_NOT:  ext = {1'b0, ~acc};
      OP_MOV:  ext = {cy, r};
      OP_ADC:  ext = {1'b0, acc} + {1'b0, r} + (WIDTH+1)'(cy);
      OP_SBB:  ext = {1'b0, acc} - {1'b0, r} - (WIDTH+1)'(cy);
      OP_SHL:  ext = {acc, cy};
      OP_SHR:  ext = {acc[0], cy, acc[WIDTH-1:1]};
      default: wr = 1'b0;
    endcase
  end
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign busy = state == MUL;
  assign mul_start = accept && op == MUL_OP;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(mul_start), .a(acc), .b(r), .done(mul_fin), .prod(prod)
  );
  assign res = mul_fin ? {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]} : ext;
  assign we = mul_fin || (accept && wr);
`else
  assign busy = 1'b0;
  assign mul_start = 1'b0;
  assign mul_fin = 1'b0;
  assign res = ext;
  assign we = accept && wr;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      cy    <= 1'b0;
      z     <= 1'b1;
      done  <= 1'b0;
      state <= IDLE;
    end else begin
      done  <= (accept && !mul_start) || mul_fin;
      state <= mul_start ? MUL : mul_fin ? IDLE : state;
      if (we) begin
        acc <= res[WIDTH-1:0];
        cy  <= res[WIDTH];
        z   <= res[WIDTH-1:0] == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq: directed and random checks of alu_acc_seq (WIDTH=8) against an arithmetic model.
module tb_alu_acc_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic in_ready, cy, z, done, busy;
  logic [3:0] op = '0;
  logic [W-1:0] r = '0, acc;
  int checks = 0, failures = 0;
  int m_acc = 0, m_cy = 0, m_z = 1;

  alu_acc_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .r(r),
    .acc(acc), .cy(cy), .z(z), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int o, input int rv);
    int t;
    int c;
    c = m_cy;
    if (o == 6) m_acc = rv;
    else if (o == 9) begin
      m_cy = m_acc / 128;
      m_acc = (m_acc * 2 + c) % 256;
    end else if (o == 10) begin
      m_cy = m_acc % 2;
      m_acc = m_acc / 2 + c * 128;
    end else if (o <= 8 || (MUL_EN && o == 11)) begin
      case (o)
        0: t = m_acc + rv;
        1: t = m_acc - rv;
        2: t = m_acc & rv;
        3: t = m_acc | rv;
        4: t = m_acc ^ rv;
        5: t = 255 - m_acc;
        7: t = m_acc + rv + c;
        8: t = m_acc - rv - c;
        default: t = m_acc * rv;
      endcase
      m_cy = (t < 0 || t > 255) ? 1 : 0;
      m_acc = t & 255;
    end else return;
    m_z = (m_acc == 0) ? 1 : 0;
  endfunction

  task automatic cmp_model(input string tag);
    check({tag, "_acc"}, 32'(acc), 32'(m_acc));
    check({tag, "_cy"}, 32'(cy), 32'(m_cy));
    check({tag, "_z"}, 32'(z), 32'(m_z));
  endtask

  task automatic expect_fixed(input string tag, input logic [7:0] ea, input logic ec, input logic ez);
    check({tag, "_acc"}, 32'(acc), 32'(ea));
    check({tag, "_cy"}, 32'(cy), 32'(ec));
    check({tag, "_z"}, 32'(z), 32'(ez));
  endtask

  // Offers a command on the current cycle and samples just after the edge that commits it.
  task automatic do_op(input logic [3:0] o, input logic [7:0] rv);
    in_valid = 1'b1;
    op = o;
    r = rv;
    @(posedge clk); #1;
`ifdef ALU_MUL_EN
    if (o == 4'd11) begin
      for (int i = 0; i < W; i++) begin
        check("mul_busy", 32'(busy), 32'd1);
        check("mul_ready", 32'(in_ready), 32'd0);
        check("mul_nodone", 32'(done), 32'd0);
        op = 4'($urandom_range(0, 10));
        r = 8'($urandom);
        @(posedge clk); #1;
      end
    end
`endif
    in_valid = 1'b0;
    model(o, rv);
    cmp_model("op");
    check("done", 32'(done), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("ready_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic idle_cycle();
    op = 4'($urandom);
    r = 8'($urandom);
    @(posedge clk); #1;
    check("idle_done", 32'(done), 32'd0);
    cmp_model("idle");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_cy", 32'(cy), 32'd0);
    check("rst_z", 32'(z), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle_cycle();
    do_op(4'd6, 8'h0A);
    do_op(4'd1, 8'h02);
    expect_fixed("sub1", 8'h08, 1'b0, 1'b0);
    do_op(4'd1, 8'h09);
    expect_fixed("sub2", 8'hFF, 1'b1, 1'b0);
    idle_cycle();
    do_op(4'd6, 8'hFF);
    do_op(4'd0, 8'h01);
    expect_fixed("add_wrap", 8'h00, 1'b1, 1'b1);
    do_op(4'd7, 8'h00);
    expect_fixed("adc", 8'h01, 1'b0, 1'b0);
    do_op(4'd6, 8'h81);
    do_op(4'd9, 8'h55);
    expect_fixed("shl", 8'h02, 1'b1, 1'b0);
    do_op(4'd10, 8'hAA);
    expect_fixed("shr", 8'h81, 1'b0, 1'b0);
    do_op(4'd1, 8'h90);
    expect_fixed("sub_borrow", 8'hF1, 1'b1, 1'b0);
    do_op(4'd2, 8'h0F);
    expect_fixed("and", 8'h01, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
    do_op(4'd6, 8'h10);
    do_op(4'd11, 8'h11);
    expect_fixed("mul1", 8'h10, 1'b1, 1'b0);
    idle_cycle();
    do_op(4'd6, 8'h0F);
    do_op(4'd11, 8'h03);
    expect_fixed("mul2", 8'h2D, 1'b0, 1'b0);
    do_op(4'd6, 8'h33);
    in_valid = 1'b1;
    op = 4'd11;
    r = 8'h07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = 0;
    m_cy = 0;
    m_z = 1;
    expect_fixed("mulrst", 8'h00, 1'b0, 1'b1);
    check("mulrst_busy", 32'(busy), 32'd0);
    check("mulrst_ready", 32'(in_ready), 32'd1);
    check("mulrst_done", 32'(done), 32'd0);
    repeat (W + 1) idle_cycle();
`else
    do_op(4'd6, 8'hC3);
    do_op(4'd9, 8'h00);
    do_op(4'd11, 8'h5A);
    expect_fixed("nop11", 8'h86, 1'b1, 1'b0);
    do_op(4'd14, 8'hA5);
    expect_fixed("nop14", 8'h86, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 300; i++) begin
      do_op(4'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
